// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format-derived constants, canonical NaN builder, flag indices.
package fp_pkg;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN right-aligned in 64 bits: {0, all-ones exp, 1, 0..0}
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W = 8
) (
  input  logic [W-1:0]             in_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(W + 1);

  // Scan upwards so the highest set bit has the final say
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end else begin
        cnt_o = cnt_o;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined FP adder/subtractor (align, add, normalise/round) with valid/ready flow.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int M       = MAN_W + 4;
  localparam int LW      = $clog2(M + 1);
  localparam int XW      = EXP_W + 8;
  localparam int EXP_MAX = fp_exp_max(EXP_W);
  localparam logic [EXP_W-1:0] EALL      = {EXP_W{1'b1}};
  localparam logic [63:0]      QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  logic adv_s;
  assign adv_s    = !out_valid | out_ready;
  assign in_ready = adv_s;

  logic             sa_s, sb_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s;
  logic [EXP_W-1:0] ea_s, eb_s, eb_big_s, diff_s;
  logic [MAN_W-1:0] fa_s, fb_s;
  logic [M-1:0]     m_big_s, m_sml_s, aligned_s;
  logic [2*M-1:0]   wide_s;

  // S1 combinational: unpack, flush subnormals, classify, order by magnitude, align small
  always_comb begin
    sa_s    = a[W-1];
    sb_s    = b[W-1] ^ op_sub;
    ea_s    = a[W-2:MAN_W];
    eb_s    = b[W-2:MAN_W];
    fa_s    = (ea_s != {EXP_W{1'b0}}) ? a[MAN_W-1:0] : {MAN_W{1'b0}};
    fb_s    = (eb_s != {EXP_W{1'b0}}) ? b[MAN_W-1:0] : {MAN_W{1'b0}};
    a_nan_s = (ea_s == EALL) && (fa_s != {MAN_W{1'b0}});
    b_nan_s = (eb_s == EALL) && (fb_s != {MAN_W{1'b0}});
    a_inf_s = (ea_s == EALL) && (fa_s == {MAN_W{1'b0}});
    b_inf_s = (eb_s == EALL) && (fb_s == {MAN_W{1'b0}});
    swap_s  = {eb_s, fb_s} > {ea_s, fa_s};
    if (swap_s) begin
      eb_big_s = eb_s;
      diff_s   = eb_s - ea_s;
      m_big_s  = {(eb_s != {EXP_W{1'b0}}), fb_s, 3'b000};
      m_sml_s  = {(ea_s != {EXP_W{1'b0}}), fa_s, 3'b000};
    end else begin
      eb_big_s = ea_s;
      diff_s   = ea_s - eb_s;
      m_big_s  = {(ea_s != {EXP_W{1'b0}}), fa_s, 3'b000};
      m_sml_s  = {(eb_s != {EXP_W{1'b0}}), fb_s, 3'b000};
    end
    wide_s = {m_sml_s, {M{1'b0}}} >> diff_s;
    if (32'(diff_s) >= 32'(M - 1)) begin
      aligned_s = {{(M-1){1'b0}}, |m_sml_s};
    end else begin
      aligned_s = {wide_s[2*M-1:M+1], wide_s[M] | (|wide_s[M-1:0])};
    end
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_isign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [M-1:0]     s1_mbig_q, s1_msml_q;

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_isign_q <= 1'b0;
      s1_exp_q   <= {EXP_W{1'b0}};
      s1_mbig_q  <= {M{1'b0}};
      s1_msml_q  <= {M{1'b0}};
    end else if (adv_s) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= swap_s ? sb_s : sa_s;
      s1_sub_q   <= sa_s ^ sb_s;
      s1_nan_q   <= a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (sa_s ^ sb_s));
      s1_inf_q   <= a_inf_s | b_inf_s;
      s1_isign_q <= a_inf_s ? sa_s : sb_s;
      s1_exp_q   <= eb_big_s;
      s1_mbig_q  <= m_big_s;
      s1_msml_q  <= aligned_s;
    end
  end

  logic             s2_valid_q, s2_sign_q, s2_sub_q, s2_nan_q, s2_inf_q, s2_isign_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [M:0]       s2_sum_q;

  // S2 register: magnitude add or subtract; ordering guarantees a non-negative difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_isign_q <= 1'b0;
      s2_exp_q   <= {EXP_W{1'b0}};
      s2_sum_q   <= {(M+1){1'b0}};
    end else if (adv_s) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_sub_q   <= s1_sub_q;
      s2_nan_q   <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;
      s2_isign_q <= s1_isign_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= s1_sub_q ? ({1'b0, s1_mbig_q} - {1'b0, s1_msml_q})
                             : ({1'b0, s1_mbig_q} + {1'b0, s1_msml_q});
    end
  end

  logic [LW-1:0]    lz_s;
  logic [M-1:0]     norm_s;
  logic [XW-1:0]    nexp_s, fexp_s;
  logic [MAN_W+1:0] rsum_s;
  logic [MAN_W-1:0] frac_s;
  logic             up_s, inx_s;
  logic [W-1:0]     res_d;
  logic [3:0]       flg_d;

  fp_lzc #(.W(M)) u_lzc (
    .in_i  (s2_sum_q[M-1:0]),
    .cnt_o (lz_s)
  );

  // S3 combinational: normalise, round to nearest even, then apply special and range cases
  always_comb begin
    if (s2_sum_q[M]) begin
      norm_s = {s2_sum_q[M:2], s2_sum_q[1] | s2_sum_q[0]};
      nexp_s = XW'(s2_exp_q) + XW'(1);
    end else begin
      norm_s = s2_sum_q[M-1:0] << lz_s;
      nexp_s = XW'(s2_exp_q) - XW'(lz_s);
    end
    inx_s  = norm_s[2] | norm_s[1] | norm_s[0];
    up_s   = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rsum_s = {1'b0, norm_s[M-1:3]} + {{(MAN_W+1){1'b0}}, up_s};
    if (rsum_s[MAN_W+1]) begin
      frac_s = rsum_s[MAN_W:1];
      fexp_s = nexp_s + XW'(1);
    end else begin
      frac_s = rsum_s[MAN_W-1:0];
      fexp_s = nexp_s;
    end
    flg_d = 4'b0000;
    if (s2_nan_q) begin
      res_d          = QNAN;
      flg_d[FLG_INV] = 1'b1;
    end else if (s2_inf_q) begin
      res_d = {s2_isign_q, EALL, {MAN_W{1'b0}}};
    end else if (s2_sum_q == {(M+1){1'b0}}) begin
      res_d = {s2_sign_q & !s2_sub_q, {(W-1){1'b0}}};
    end else if (!fexp_s[XW-1] && ($signed(fexp_s) >= $signed(XW'(EXP_MAX)))) begin
      res_d          = {s2_sign_q, EALL, {MAN_W{1'b0}}};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else if (fexp_s[XW-1] || (fexp_s == {XW{1'b0}})) begin
      res_d          = {s2_sign_q, {(W-1){1'b0}}};
      flg_d[FLG_UNF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else begin
      res_d          = {s2_sign_q, fexp_s[EXP_W-1:0], frac_s};
      flg_d[FLG_INX] = inx_s;
    end
  end

  // Output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      flags     <= 4'b0000;
    end else if (adv_s) begin
      out_valid <= s2_valid_q;
      result    <= res_d;
      flags     <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed fp32 vectors for fp_addsub_pipe: arithmetic, rounding, specials, stall and reset behaviour.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated operation: checks latency, result and flags
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vs, input logic [31:0] er, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    a = va; b = vb; op_sub = vs; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_res"}, 64'(result), 64'(er));
    check({tag, "_flg"}, 64'(flags), 64'(ef));
  endtask

  logic [31:0] sb_in  [8];
  logic [31:0] sb_exp [8];
  int n_in, n_out, stale;

  initial begin
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_op("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("above_tie", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    run_op("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_op("nan_in",    32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("inf_p_1",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    run_op("zero_p_x",  32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 4'b0000);
    run_op("subn_flush",32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    run_op("nz_p_nz",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("pz_m_pz",   32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000);
    run_op("cancel",    32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000);
    run_op("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011);

    // Stream 1.0 + k for k=1..6 against a stalled consumer
    sb_in  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h0, 32'h0};
    sb_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h0, 32'h0};
    n_in = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 8) begin
        check("stall_accepts", 64'(n_in), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = (cyc >= 8);
      in_valid  = (n_in < 6);
      a = 32'h3F800000;
      b = sb_in[n_in];
      op_sub = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (n_out < 6) check($sformatf("stream_%0d", n_out), 64'(result), 64'(sb_exp[n_out]));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(n_out), 64'd6);

    // Fill the pipe with three ops (one at the output), then reset
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 64'(stale), 64'd0);

    run_op("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
